vga_plot_arbiter: RTL and testbench

//  Shares the single vga_adapter pixel-write port between the paddle and ball drawers.

---
 rtl/pong_pkg.sv | 23 ++
 rtl/vga_pixel_reg.sv | 43 ++++
 rtl/vga_plot_arbiter.sv | 135 +++++++++++++
 tb/tb_vga_plot_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants and types for the pong pixel path: screen bounds,
// arbiter owner encodings and arbiter FSM states.
package pong_pkg;

  localparam int unsigned SCREEN_X_MAX = 159;
  localparam int unsigned SCREEN_Y_MAX = 119;

  localparam logic [1:0] OWNER_NONE   = 2'b00;
  localparam logic [1:0] OWNER_PADDLE = 2'b01;
  localparam logic [1:0] OWNER_BALL   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_P = 2'd1,
    ST_GRANT_B = 2'd2,
    ST_GAP     = 2'd3
  } arb_state_t;

  function automatic logic in_frame(input int unsigned x, input int unsigned y);
    return (x <= SCREEN_X_MAX) && (y <= SCREEN_Y_MAX);
  endfunction

endpackage

// File: rtl/vga_pixel_reg.sv
// Output register feeding vga_adapter: one-cycle pixel pipeline that
// suppresses the plot strobe for pixels outside the visible frame.
module vga_pixel_reg
  import pong_pkg::*;
#(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int C_W = 3
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           accept,
  input  logic [X_W-1:0] pix_x,
  input  logic [Y_W-1:0] pix_y,
  input  logic [C_W-1:0] pix_colour,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_colour,
  output logic           vga_plot
);

  logic visible;

  assign visible = in_frame(32'(pix_x), 32'(pix_y));

  // Clipped pixels still leave the bus showing the last pixel actually drawn.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= accept && visible;
      if (accept && visible) begin
        vga_x      <= pix_x;
        vga_y      <= pix_y;
        vga_colour <= pix_colour;
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin, bursted arbiter sharing the vga_adapter pixel port between
// the paddle and ball drawers.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no grant; picks a requester, rr pointer breaks ties
// ST_GRANT_P | paddle owns the port; req is acked combinationally
// ST_GRANT_B | ball owns the port; req is acked combinationally
// ST_GAP     | idle spacing between grants, counted down from GAP_CYCLES
module vga_plot_arbiter
  import pong_pkg::*;
#(
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int C_W        = 3,
  parameter int MAX_BURST  = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           p_req,
  input  logic [X_W-1:0] p_x,
  input  logic [Y_W-1:0] p_y,
  input  logic [C_W-1:0] p_colour,
  input  logic           p_last,
  output logic           p_ack,
  input  logic           b_req,
  input  logic [X_W-1:0] b_x,
  input  logic [Y_W-1:0] b_y,
  input  logic [C_W-1:0] b_colour,
  input  logic           b_last,
  output logic           b_ack,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_colour,
  output logic           vga_plot,
  output logic [1:0]     owner
);

  localparam logic [7:0] BURST_TC = 8'(MAX_BURST - 1);
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  arb_state_t state, state_nxt;
  logic       rr_ball, rr_ball_nxt;
  logic [7:0] burst_cnt, burst_nxt;
  logic [3:0] gap_cnt, gap_nxt;
  logic       grant_exit;
  logic       sel_ball;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      rr_ball   <= 1'b0;
      burst_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      rr_ball   <= rr_ball_nxt;
      burst_cnt <= burst_nxt;
      gap_cnt   <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rr_ball_nxt = rr_ball;
    burst_nxt   = burst_cnt;
    gap_nxt     = gap_cnt;
    p_ack       = 1'b0;
    b_ack       = 1'b0;
    owner       = OWNER_NONE;
    sel_ball    = 1'b0;
    grant_exit  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (p_req && b_req) state_nxt = rr_ball ? ST_GRANT_B : ST_GRANT_P;
        else if (p_req)     state_nxt = ST_GRANT_P;
        else if (b_req)     state_nxt = ST_GRANT_B;
      end
      ST_GRANT_P: begin
        owner = OWNER_PADDLE;
        p_ack = p_req;
        if (p_req) begin
          burst_nxt  = burst_cnt + 8'd1;
          grant_exit = p_last || (burst_cnt == BURST_TC);
        end else begin
          grant_exit = 1'b1;
        end
      end
      ST_GRANT_B: begin
        owner    = OWNER_BALL;
        sel_ball = 1'b1;
        b_ack    = b_req;
        if (b_req) begin
          burst_nxt  = burst_cnt + 8'd1;
          grant_exit = b_last || (burst_cnt == BURST_TC);
        end else begin
          grant_exit = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == 4'd0) state_nxt = ST_IDLE;
        else                 gap_nxt   = gap_cnt - 4'd1;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // last and burst limit on the same pixel collapse into this single exit.
    if (grant_exit) begin
      rr_ball_nxt = (state == ST_GRANT_P);
      burst_nxt   = '0;
      gap_nxt     = GAP_LOAD;
      state_nxt   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
    end
  end

  vga_pixel_reg #(
    .X_W(X_W),
    .Y_W(Y_W),
    .C_W(C_W)
  ) u_pixel_reg (
    .clock      (clock),
    .resetn     (resetn),
    .accept     (p_ack | b_ack),
    .pix_x      (sel_ball ? b_x : p_x),
    .pix_y      (sel_ball ? b_y : p_y),
    .pix_colour (sel_ball ? b_colour : p_colour),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: default instance plus a GAP_CYCLES=0
// instance, both fed by the same requester model.
module tb_vga_plot_arbiter;

  logic       clock = 1'b0;
  logic       resetn;
  logic       p_req, b_req, p_last, b_last;
  logic [7:0] p_x, b_x;
  logic [6:0] p_y, b_y;
  logic [2:0] p_colour, b_colour;

  logic       p_ack0, b_ack0, vga_plot0;
  logic [7:0] vga_x0;
  logic [6:0] vga_y0;
  logic [2:0] vga_colour0;
  logic [1:0] owner0;

  logic       p_ack1, b_ack1, vga_plot1;
  logic [7:0] vga_x1;
  logic [6:0] vga_y1;
  logic [2:0] vga_colour1;
  logic [1:0] owner1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  vga_plot_arbiter #(.X_W(8), .Y_W(7), .C_W(3), .MAX_BURST(16), .GAP_CYCLES(1)) dut0 (
    .clock(clock), .resetn(resetn),
    .p_req(p_req), .p_x(p_x), .p_y(p_y), .p_colour(p_colour), .p_last(p_last), .p_ack(p_ack0),
    .b_req(b_req), .b_x(b_x), .b_y(b_y), .b_colour(b_colour), .b_last(b_last), .b_ack(b_ack0),
    .vga_x(vga_x0), .vga_y(vga_y0), .vga_colour(vga_colour0), .vga_plot(vga_plot0),
    .owner(owner0)
  );

  vga_plot_arbiter #(.X_W(8), .Y_W(7), .C_W(3), .MAX_BURST(16), .GAP_CYCLES(0)) dut1 (
    .clock(clock), .resetn(resetn),
    .p_req(p_req), .p_x(p_x), .p_y(p_y), .p_colour(p_colour), .p_last(p_last), .p_ack(p_ack1),
    .b_req(b_req), .b_x(b_x), .b_y(b_y), .b_colour(b_colour), .b_last(b_last), .b_ack(b_ack1),
    .vga_x(vga_x1), .vga_y(vga_y1), .vga_colour(vga_colour1), .vga_plot(vga_plot1),
    .owner(owner1)
  );

  // Requester pixel lists; each side advances only on its own ack.
  logic [7:0] pq_x[64], bq_x[64];
  logic [6:0] pq_y[64], bq_y[64];
  logic [2:0] pq_c[64], bq_c[64];
  logic       pq_l[64], bq_l[64];
  int         p_n, b_n, p_idx, b_idx;
  bit         p_en, b_en;
  int         sel;

  // Per-cycle trace of the selected instance.
  logic [63:0] l_pa, l_ba, l_plot;
  logic [1:0]  l_own[64];
  logic [17:0] plotted[$];
  logic [17:0] exp_q[$];
  int          cyc;

  function automatic logic [63:0] mask(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [17:0] pix(input int x, input int y, input int c);
    return {8'(x), 7'(y), 3'(c)};
  endfunction

  task automatic set_p(input int i, input int x, input int y, input int c, input logic l);
    pq_x[i] = 8'(x); pq_y[i] = 7'(y); pq_c[i] = 3'(c); pq_l[i] = l;
  endtask

  task automatic set_b(input int i, input int x, input int y, input int c, input logic l);
    bq_x[i] = 8'(x); bq_y[i] = 7'(y); bq_c[i] = 3'(c); bq_l[i] = l;
  endtask

  task automatic drive_inputs();
    p_req = p_en && (p_idx < p_n);
    b_req = b_en && (b_idx < b_n);
    if (p_idx < p_n) begin
      p_x = pq_x[p_idx]; p_y = pq_y[p_idx]; p_colour = pq_c[p_idx]; p_last = pq_l[p_idx];
    end else begin
      p_x = '0; p_y = '0; p_colour = '0; p_last = 1'b0;
    end
    if (b_idx < b_n) begin
      b_x = bq_x[b_idx]; b_y = bq_y[b_idx]; b_colour = bq_c[b_idx]; b_last = bq_l[b_idx];
    end else begin
      b_x = '0; b_y = '0; b_colour = '0; b_last = 1'b0;
    end
  endtask

  task automatic clear_log();
    l_pa = '0; l_ba = '0; l_plot = '0;
    foreach (l_own[i]) l_own[i] = 2'b00;
    plotted.delete();
    exp_q.delete();
    cyc = 0;
  endtask

  task automatic step();
    logic pa, ba, pl;
    logic [1:0] own;
    logic [17:0] px;
    @(negedge clock);
    pa  = (sel != 0) ? p_ack1 : p_ack0;
    ba  = (sel != 0) ? b_ack1 : b_ack0;
    pl  = (sel != 0) ? vga_plot1 : vga_plot0;
    own = (sel != 0) ? owner1 : owner0;
    px  = (sel != 0) ? {vga_x1, vga_y1, vga_colour1} : {vga_x0, vga_y0, vga_colour0};
    if (cyc < 64) begin
      l_pa[cyc] = pa; l_ba[cyc] = ba; l_plot[cyc] = pl; l_own[cyc] = own;
    end
    if (pl === 1'b1) plotted.push_back(px);
    cyc++;
    @(posedge clock);
    #1;
    if (pa === 1'b1) p_idx++;
    if (ba === 1'b1) b_idx++;
    drive_inputs();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    p_en = 1'b0; b_en = 1'b0;
    p_idx = 0; b_idx = 0; p_n = 0; b_n = 0;
    drive_inputs();
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    clear_log();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    p_idx = 0; b_idx = 0;
    set_p(0, 1, 1, 1, 1'b1); p_n = 1; p_en = 1'b1;
    set_b(0, 2, 2, 2, 1'b1); b_n = 1; b_en = 1'b1;
    drive_inputs();
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (p_ack0 !== 1'b0) begin errors++; $display("FAIL reset_p_ack got %b exp 0", p_ack0); end
    checks++; if (b_ack0 !== 1'b0) begin errors++; $display("FAIL reset_b_ack got %b exp 0", b_ack0); end
    checks++; if (vga_plot0 !== 1'b0) begin errors++; $display("FAIL reset_plot got %b exp 0", vga_plot0); end
    checks++; if (owner0 !== 2'b00) begin errors++; $display("FAIL reset_owner got %b exp 00", owner0); end
    checks++; if ({vga_x0, vga_y0, vga_colour0} !== 18'd0)
      begin errors++; $display("FAIL reset_xyc got %h exp 0", {vga_x0, vga_y0, vga_colour0}); end
    checks++; if (owner1 !== 2'b00) begin errors++; $display("FAIL reset_owner_gap0 got %b exp 00", owner1); end
  endtask

  task automatic test_single();
    do_reset();
    sel = 0;
    for (int i = 0; i < 4; i++) set_p(i, 10 + i, 118, i + 1, i == 3);
    p_n = 4; p_en = 1'b1;
    drive_inputs();
    repeat (8) step();
    checks++; if (l_pa !== mask(1, 4)) begin errors++; $display("FAIL t1_p_ack got %h exp %h", l_pa, mask(1, 4)); end
    checks++; if (l_ba !== 64'd0) begin errors++; $display("FAIL t1_b_ack got %h exp 0", l_ba); end
    checks++; if (l_plot !== mask(2, 5)) begin errors++; $display("FAIL t1_plot got %h exp %h", l_plot, mask(2, 5)); end
    checks++; if (l_own[0] !== 2'b00) begin errors++; $display("FAIL t1_owner_c0 got %b exp 00", l_own[0]); end
    checks++; if (l_own[1] !== 2'b01) begin errors++; $display("FAIL t1_owner_c1 got %b exp 01", l_own[1]); end
    checks++; if (l_own[4] !== 2'b01) begin errors++; $display("FAIL t1_owner_c4 got %b exp 01", l_own[4]); end
    checks++; if (l_own[5] !== 2'b00) begin errors++; $display("FAIL t1_owner_c5 got %b exp 00", l_own[5]); end
    for (int i = 0; i < 4; i++) exp_q.push_back(pix(10 + i, 118, i + 1));
    checks++; if (plotted.size() != exp_q.size())
      begin errors++; $display("FAIL t1_count got %0d exp %0d", plotted.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < plotted.size(); i++) begin
      checks++; if (plotted[i] !== exp_q[i])
        begin errors++; $display("FAIL t1_pixel%0d got %h exp %h", i, plotted[i], exp_q[i]); end
    end
  endtask

  task automatic test_tie();
    do_reset();
    sel = 0;
    for (int i = 0; i < 6; i++) begin
      set_p(i, 20 + i, 40, i, (i % 3) == 2);
      set_b(i, 60 + i, 41, 7 - i, (i % 3) == 2);
    end
    p_n = 6; b_n = 6; p_en = 1'b1; b_en = 1'b1;
    drive_inputs();
    repeat (22) step();
    checks++; if (l_pa !== (mask(1, 3) | mask(11, 13)))
      begin errors++; $display("FAIL t2_p_ack got %h exp %h", l_pa, mask(1, 3) | mask(11, 13)); end
    checks++; if (l_ba !== (mask(6, 8) | mask(16, 18)))
      begin errors++; $display("FAIL t2_b_ack got %h exp %h", l_ba, mask(6, 8) | mask(16, 18)); end
    checks++; if (l_plot !== (mask(2, 4) | mask(7, 9) | mask(12, 14) | mask(17, 19)))
      begin errors++; $display("FAIL t2_plot got %h", l_plot); end
    for (int s = 0; s < 2; s++) begin
      for (int i = 3 * s; i < 3 * s + 3; i++) exp_q.push_back(pix(20 + i, 40, i));
      for (int i = 3 * s; i < 3 * s + 3; i++) exp_q.push_back(pix(60 + i, 41, 7 - i));
    end
    checks++; if (plotted.size() != exp_q.size())
      begin errors++; $display("FAIL t2_count got %0d exp %0d", plotted.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < plotted.size(); i++) begin
      checks++; if (plotted[i] !== exp_q[i])
        begin errors++; $display("FAIL t2_pixel%0d got %h exp %h", i, plotted[i], exp_q[i]); end
    end
  endtask

  task automatic test_burst();
    do_reset();
    sel = 0;
    for (int i = 0; i < 40; i++) set_b(i, 20 + i, 30, i % 8, 1'b0);
    for (int i = 0; i < 3; i++) set_p(i, 100 + i, 5, 2, i == 2);
    b_n = 40; p_n = 3; b_en = 1'b1;
    drive_inputs();
    repeat (3) step();
    p_en = 1'b1;
    drive_inputs();
    repeat (53) step();
    checks++; if (l_pa !== mask(19, 21))
      begin errors++; $display("FAIL t3_p_ack got %h exp %h", l_pa, mask(19, 21)); end
    checks++; if (l_ba !== (mask(1, 16) | mask(24, 39) | mask(42, 49)))
      begin errors++; $display("FAIL t3_b_ack got %h exp %h", l_ba, mask(1, 16) | mask(24, 39) | mask(42, 49)); end
    checks++; if (l_plot !== (mask(2, 17) | mask(20, 22) | mask(25, 40) | mask(43, 50)))
      begin errors++; $display("FAIL t3_plot got %h", l_plot); end
    for (int i = 0; i < 16; i++) exp_q.push_back(pix(20 + i, 30, i % 8));
    for (int i = 0; i < 3; i++) exp_q.push_back(pix(100 + i, 5, 2));
    for (int i = 16; i < 40; i++) exp_q.push_back(pix(20 + i, 30, i % 8));
    checks++; if (plotted.size() != exp_q.size())
      begin errors++; $display("FAIL t3_count got %0d exp %0d", plotted.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < plotted.size(); i++) begin
      checks++; if (plotted[i] !== exp_q[i])
        begin errors++; $display("FAIL t3_pixel%0d got %h exp %h", i, plotted[i], exp_q[i]); end
    end
  endtask

  task automatic test_clip();
    do_reset();
    sel = 0;
    set_p(0, 160, 50, 1, 1'b0);
    set_p(1, 5, 120, 2, 1'b0);
    set_p(2, 5, 119, 3, 1'b1);
    p_n = 3; p_en = 1'b1;
    drive_inputs();
    repeat (7) step();
    checks++; if (l_pa !== mask(1, 3)) begin errors++; $display("FAIL t4_p_ack got %h exp %h", l_pa, mask(1, 3)); end
    checks++; if (l_plot !== mask(4, 4)) begin errors++; $display("FAIL t4_plot got %h exp %h", l_plot, mask(4, 4)); end
    checks++; if (plotted.size() != 1) begin errors++; $display("FAIL t4_count got %0d exp 1", plotted.size()); end
    if (plotted.size() > 0) begin
      checks++; if (plotted[0] !== pix(5, 119, 3))
        begin errors++; $display("FAIL t4_pixel got %h exp %h", plotted[0], pix(5, 119, 3)); end
    end
  endtask

  // Runs straight after test_clip so the rr pointer is left at ball.
  task automatic test_reset_mid();
    clear_log();
    sel = 0;
    p_en = 1'b0; p_idx = 0; p_n = 0;
    for (int i = 0; i < 5; i++) set_b(i, 70 + i, 60, i, i == 4);
    b_n = 5; b_idx = 0; b_en = 1'b1;
    drive_inputs();
    repeat (2) step();
    resetn = 1'b0;
    repeat (2) step();
    checks++; if (l_ba[2] !== 1'b1) begin errors++; $display("FAIL t5_b_ack_c2 got %b exp 1", l_ba[2]); end
    checks++; if (l_plot[2] !== 1'b1) begin errors++; $display("FAIL t5_plot_c2 got %b exp 1", l_plot[2]); end
    checks++; if (l_plot[3] !== 1'b0) begin errors++; $display("FAIL t5_plot_after_rst got %b exp 0", l_plot[3]); end
    checks++; if ({l_pa[3], l_ba[3]} !== 2'b00)
      begin errors++; $display("FAIL t5_acks_after_rst got %b exp 00", {l_pa[3], l_ba[3]}); end
    checks++; if (l_own[3] !== 2'b00) begin errors++; $display("FAIL t5_owner_after_rst got %b exp 00", l_own[3]); end
    for (int i = 0; i < 3; i++) set_p(i, 30 + i, 20, 4, i == 2);
    p_n = 3; p_idx = 0; p_en = 1'b1;
    drive_inputs();
    resetn = 1'b1;
    clear_log();
    repeat (3) step();
    checks++; if ({l_pa[1], l_ba[1]} !== 2'b10)
      begin errors++; $display("FAIL t5_tie_after_rst got %b exp 10", {l_pa[1], l_ba[1]}); end
    checks++; if (l_own[1] !== 2'b01) begin errors++; $display("FAIL t5_owner_tie got %b exp 01", l_own[1]); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] e_pa, e_ba, e_pl;
    do_reset();
    sel = 1;
    for (int i = 0; i < 4; i++) begin
      set_p(i, 10 + i, 10, 1, 1'b1);
      set_b(i, 90 + i, 90, 6, 1'b1);
    end
    p_n = 4; b_n = 4; p_en = 1'b1; b_en = 1'b1;
    drive_inputs();
    repeat (18) step();
    e_pa = '0; e_ba = '0; e_pl = '0;
    for (int k = 0; k < 4; k++) begin
      e_pa[1 + 4 * k] = 1'b1;
      e_ba[3 + 4 * k] = 1'b1;
      exp_q.push_back(pix(10 + k, 10, 1));
      exp_q.push_back(pix(90 + k, 90, 6));
    end
    for (int k = 2; k <= 16; k += 2) e_pl[k] = 1'b1;
    checks++; if (l_pa !== e_pa) begin errors++; $display("FAIL t6_p_ack got %h exp %h", l_pa, e_pa); end
    checks++; if (l_ba !== e_ba) begin errors++; $display("FAIL t6_b_ack got %h exp %h", l_ba, e_ba); end
    checks++; if (l_plot !== e_pl) begin errors++; $display("FAIL t6_plot got %h exp %h", l_plot, e_pl); end
    checks++; if (plotted.size() != exp_q.size())
      begin errors++; $display("FAIL t6_count got %0d exp %0d", plotted.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < plotted.size(); i++) begin
      checks++; if (plotted[i] !== exp_q[i])
        begin errors++; $display("FAIL t6_pixel%0d got %h exp %h", i, plotted[i], exp_q[i]); end
    end
    sel = 0;
  endtask

  initial begin
    resetn = 1'b0;
    sel = 0;
    p_en = 1'b0; b_en = 1'b0;
    p_n = 0; b_n = 0; p_idx = 0; b_idx = 0;
    drive_inputs();
    clear_log();
    test_reset();
    test_single();
    test_tie();
    test_burst();
    test_clip();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
